// File: rtl/johnson_pkg.sv
// Shared Johnson-code definitions for the 6-bit twisted-ring counter stage and its consumers.
package johnson_pkg;

    localparam int unsigned JW  = 6;
    localparam int unsigned MOD = 12;
    localparam int unsigned BW  = 4;

    // Legal ring patterns in value order 0..11
    localparam logic [JW-1:0] LEGAL_CODES [MOD] = '{
        6'b000000, 6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b011111,
        6'b111111, 6'b111110, 6'b111100, 6'b111000, 6'b110000, 6'b100000
    };

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [BW-1:0] value;
        logic          valid;
    } decode_t;

    // Illegal (or unknown) codes decode to value 0 with valid low
    function automatic decode_t johnson_to_bin(input logic [JW-1:0] code);
        decode_t r;
        r.value = '0;
        r.valid = 1'b0;
        for (int i = 0; i < int'(MOD); i++) begin
            if (code == LEGAL_CODES[i]) begin
                r.value = BW'(i);
                r.valid = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson-to-binary decode with a legality flag.
module johnson_decode
    import johnson_pkg::*;
(
    input  logic [JW-1:0] code,
    output logic [BW-1:0] value,
    output logic          valid
);

    decode_t dec;

    always_comb begin
        dec   = johnson_to_bin(code);
        value = dec.value;
        valid = dec.valid;
    end

endmodule

// File: rtl/johnson_mod12_accumulator.sv
// Mod-12 Johnson-code accumulator: adds each accepted digit by stepping a twisted ring once per clock.
// Optional sum-ring self-check enabled by defining JOHNSON_ACC_SELFCHECK_EN.
module johnson_mod12_accumulator
    import johnson_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [JW-1:0] in_code,
    output logic [JW-1:0] sum_code,
    output logic [BW-1:0] sum_bin,
    output logic [CW-1:0] carry_count,
    output logic          carry_pulse,
    output logic          code_error,
`ifdef JOHNSON_ACC_SELFCHECK_EN
    output logic          selfcheck_err,
`endif
    output logic          busy
);

    state_t        state, state_n;
    logic [BW-1:0] remaining, remaining_n;
    logic [JW-1:0] sum_n;
    logic [CW-1:0] carry_n;
    logic          carry_pulse_n, code_error_n;
    logic [BW-1:0] in_value, sum_value;
    logic          in_ok, sum_ok;
`ifdef JOHNSON_ACC_SELFCHECK_EN
    logic          selfcheck_n;
`endif

    johnson_decode u_in_dec  (.code(in_code),  .value(in_value),  .valid(in_ok));
    johnson_decode u_sum_dec (.code(sum_code), .value(sum_value), .valid(sum_ok));

    assign in_ready = (state == IDLE) && !clear;
    assign sum_bin  = sum_ok ? sum_value : BW'(0);
    assign busy     = (state == ADD);

    // Next-state and datapath update
    always_comb begin
        state_n       = state;
        remaining_n   = remaining;
        sum_n         = sum_code;
        carry_n       = carry_count;
        carry_pulse_n = 1'b0;
        code_error_n  = 1'b0;
`ifdef JOHNSON_ACC_SELFCHECK_EN
        selfcheck_n   = selfcheck_err;
`endif
        if (clear) begin
            state_n     = IDLE;
            remaining_n = '0;
            sum_n       = '0;
            carry_n     = '0;
`ifdef JOHNSON_ACC_SELFCHECK_EN
            selfcheck_n = 1'b0;
        end else if (!sum_ok) begin
            state_n     = IDLE;
            remaining_n = '0;
            sum_n       = '0;
            selfcheck_n = 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!in_ok) begin
                            code_error_n = 1'b1;
                        end else if (in_value != BW'(0)) begin
                            remaining_n = in_value;
                            state_n     = ADD;
                        end
                    end
                end
                ADD: begin
                    sum_n       = {sum_code[JW-2:0], ~sum_code[JW-1]};
                    remaining_n = remaining - BW'(1);
                    // Stepping out of 100000 is the 11 -> 0 wrap
                    if (sum_code == LEGAL_CODES[MOD-1]) begin
                        carry_n       = carry_count + CW'(1);
                        carry_pulse_n = 1'b1;
                    end
                    if (remaining == BW'(1)) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= '0;
            sum_code    <= '0;
            carry_count <= '0;
            carry_pulse <= 1'b0;
            code_error  <= 1'b0;
`ifdef JOHNSON_ACC_SELFCHECK_EN
            selfcheck_err <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            remaining   <= remaining_n;
            sum_code    <= sum_n;
            carry_count <= carry_n;
            carry_pulse <= carry_pulse_n;
            code_error  <= code_error_n;
`ifdef JOHNSON_ACC_SELFCHECK_EN
            selfcheck_err <= selfcheck_n;
`endif
        end
    end

endmodule

// File: doc/johnson_mod12_accumulator.md
Name: johnson_mod12_accumulator

Overview:
- Downstream consumer of the 6-bit Johnson (twisted-ring) counter stage.
- Accepts a Johnson-coded mod-12 digit per transaction and adds it into a running mod-12 sum, also held in Johnson code.
- Performs each add by stepping its own twisted ring one position per clock.
- Counts wrap-arounds (carries) and flags illegal input codes.

Parameters:
- CW, 8, width of carry_count (wraps modulo 2^CW).

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- clear  input  1  synchronous clear of sum and carry count.
- in_valid  input  1  in_code is presented.
- in_ready  output  1  block can accept in_code this cycle.
- in_code  input  6  Johnson-coded digit 0..11.
- sum_code  output  6  running sum, Johnson code.
- sum_bin  output  4  binary equivalent of sum_code, 0..11.
- carry_count  output  CW  number of wraps 11->0 since reset/clear.
- carry_pulse  output  1  one-cycle pulse on each wrap.
- code_error  output  1  one-cycle pulse: accepted in_code was illegal.
- busy  output  1  high while in ADD state.

Behaviour:
- Legal codes, value order 0..11: 000000, 000001, 000011, 000111, 001111, 011111, 111111, 111110, 111100, 111000, 110000, 100000.
- Reset values: sum_code=000000, sum_bin=0, carry_count=0, carry_pulse=0, code_error=0, busy=0, state=IDLE, remaining=0.
- States: IDLE, ADD.
- in_ready = (state==IDLE) && !clear.
- Accept: in_valid && in_ready at a rising edge.
- IDLE, accept, legal code value k:
  - k=0: stay IDLE; no change to the sum.
  - k>0: remaining=k, go to ADD.
- IDLE, accept, illegal code: code_error=1 for the next cycle; input is consumed and discarded; sum unchanged; stay IDLE.
- ADD step, every cycle:
  - sum_code <= {sum_code[4:0], ~sum_code[5]}.
  - remaining decrements.
  - If sum_code was 100000 (value 11), then in the same edge carry_count increments and carry_pulse=1 for one cycle.
  - When remaining reaches 0, return to IDLE.
- Latency:
  - Add of k takes k cycles in ADD.
  - in_ready reasserts the cycle after the last step.
  - Back-to-back throughput is one digit per k+1 cycles; k=0 accepts every cycle.
- sum_bin: combinational decode of sum_code. An illegal sum_code decodes to 0 and cannot arise without the optional feature's fault path.
- clear: highest priority below reset.
  - Forces sum_code=000000, carry_count=0, state=IDLE, remaining=0.
  - Aborts an ADD in progress; the partial add is lost.
  - Any in_valid in the same cycle is not accepted.
  - carry_pulse and code_error are 0 the following cycle.
- Wrap: carry_count rolls over from 2^CW-1 to 0 silently; carry_pulse still fires.
- Reset mid-ADD: immediate return to reset values; no pulse generated.
- in_code may change freely while in_ready=0; it is ignored.

Optional Feature:
- Macro: JOHNSON_ACC_SELFCHECK_EN.
- Defined:
  - Each cycle, sum_code is checked against the 12 legal patterns.
  - On an illegal pattern (SEU, X), the next edge forces sum_code=000000, state=IDLE, remaining=0, and sets sticky output selfcheck_err (1 bit, extra port).
  - selfcheck_err clears only on reset or clear.
- Undefined: no check, no selfcheck_err port; illegal ring states propagate as-is.

Decomposition:
- Shared package johnson_pkg:
  - Constants: JW=6, MOD=12.
  - 12-entry legal-code constant array.
  - State enum {IDLE, ADD}.
  - Function johnson_to_bin returning 4-bit value plus valid flag. Reused by the counter stage decode.
- Sub-module johnson_decode: combinational 6-bit to 4-bit plus valid. Instantiated twice: once for in_code, once for sum_code.

Test Plan:
- Reset then add code 000111 (3): busy 3 cycles; sum_code=000111, sum_bin=3, carry_count=0, in_ready back on cycle 4.
- From sum 10 (110000), add 011111 (5): sum_bin=3 (000111); carry_pulse exactly once, on the second step; carry_count=1.
- Stream 12 digits of 000001 (1) from reset: sum back to 000000; carry_count=1; each accept spaced 2 cycles.
- Present illegal 010101 in IDLE: code_error pulse 1 cycle; sum unchanged; next legal digit accepted normally.
- Assert clear on 2nd cycle of adding 100000 (11): sum=000000, carry_count=0, state IDLE; in_valid that cycle not accepted.
- With JOHNSON_ACC_SELFCHECK_EN: force sum_code=101010 → next edge sum=000000, selfcheck_err=1 until clear. Also: assert reset mid-ADD → all outputs at reset values asynchronously.
